// File: rtl/branch_predict_fetch.sv
// Fetch-stage PC generator with a 2-bit bimodal branch history table.
// Predicts from the BHT, trains it from EX resolution, and redirects fetch on a misprediction.
module branch_predict_fetch #(
    parameter int          BHT_IDX_BITS = 6,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [1:0]  INIT_CTR     = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    output logic [31:0] pc_f,
    input  logic [31:0] dec_pc_plus_4,
    input  logic [31:0] dec_pc_target,
    input  logic        dec_is_branch,
    input  logic        dec_is_jump,
    output logic        pred_taken_f,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pc_plus_4,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

    logic [1:0]              bht [BHT_ENTRIES];
    logic [BHT_IDX_BITS-1:0] idx_f;
    logic [BHT_IDX_BITS-1:0] idx_ex;
    logic                    ex_resolve;
    logic [31:0]             next_pc;
    logic                    unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign idx_f          = pc_f[BHT_IDX_BITS+1:2];
    assign idx_ex         = ex_pc[BHT_IDX_BITS+1:2];
    assign unused_pc_bits = ^{ex_pc[31:BHT_IDX_BITS+2], ex_pc[1:0]};
    assign ex_resolve     = ex_valid & ex_is_branch;

    // Prediction reads the pre-edge counter, so a same-cycle update shows up one cycle later.
    always_comb begin
        pred_taken_f = dec_is_jump | (dec_is_branch & bht[idx_f][1]);
        mispredict   = ex_resolve & (ex_taken != ex_pred_taken);
    end

    always_comb begin
        next_pc = dec_pc_plus_4;
        if (mispredict) begin
            next_pc = ex_taken ? ex_target : ex_pc_plus_4;
        end else if (stall_f) begin
            next_pc = pc_f;
        end else if (pred_taken_f) begin
            next_pc = dec_pc_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f        <= RESET_PC;
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else begin
            pc_f <= next_pc;
            if (ex_resolve) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    // Training ignores stall_f: a resolved branch always updates its counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= INIT_CTR;
            end
        end else if (ex_resolve) begin
            bht[idx_ex] <= ex_taken ? sat_inc(bht[idx_ex]) : sat_dec(bht[idx_ex]);
        end
    end

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Bench for branch_predict_fetch: directed vectors checked every cycle against an
// integer-level model of the predictor, plus hand-computed literal expectations.
module tb_branch_predict_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f;
    logic [31:0] pc_f;
    logic [31:0] dec_pc_plus_4;
    logic [31:0] dec_pc_target;
    logic        dec_is_branch;
    logic        dec_is_jump;
    logic        pred_taken_f;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_pc_plus_4;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int unsigned m_pc;
    int          m_ctr [64];
    int unsigned m_bc;
    int unsigned m_mc;

    branch_predict_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .pc_f          (pc_f),
        .dec_pc_plus_4 (dec_pc_plus_4),
        .dec_pc_target (dec_pc_target),
        .dec_is_branch (dec_is_branch),
        .dec_is_jump   (dec_is_jump),
        .pred_taken_f  (pred_taken_f),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_pc_plus_4  (ex_pc_plus_4),
        .ex_target     (ex_target),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .mispredict    (mispredict),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_bc = 0;
        m_mc = 0;
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    endtask

    function automatic int idx_of(input int unsigned pc);
        return int'((pc >> 2) % 64);
    endfunction

    // Idle defaults; the fall-through follows the model PC.
    task automatic idle();
        stall_f       = 1'b0;
        dec_is_branch = 1'b0;
        dec_is_jump   = 1'b0;
        dec_pc_target = 32'h0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_pc         = 32'h0;
        ex_pc_plus_4  = 32'h0;
        ex_target     = 32'h0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
        dec_pc_plus_4 = m_pc + 4;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred,
                           input logic [31:0] target);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_pc_plus_4  = pc + 32'd4;
        ex_target     = target;
        ex_taken      = taken;
        ex_pred_taken = pred;
    endtask

    // Compare all outputs with the model for the current inputs, then advance one clock.
    task automatic cycle();
        logic        e_pred;
        logic        e_mis;
        logic        e_res;
        int unsigned e_next;
        int          k;
        #1;
        e_pred = dec_is_jump | (dec_is_branch & (m_ctr[idx_of(m_pc)] >= 2));
        e_res  = ex_valid & ex_is_branch;
        e_mis  = e_res & (ex_taken != ex_pred_taken);
        if (e_mis)        e_next = ex_taken ? ex_target : ex_pc_plus_4;
        else if (stall_f) e_next = m_pc;
        else if (e_pred)  e_next = dec_pc_target;
        else              e_next = dec_pc_plus_4;
        check("pc_f", pc_f, m_pc);
        check("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e_pred});
        check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        check("branch_cnt", branch_cnt, m_bc);
        check("mispred_cnt", mispred_cnt, m_mc);
        m_pc = e_next;
        if (e_res) begin
            k = idx_of(ex_pc);
            m_ctr[k] = ex_taken ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            m_bc++;
        end
        if (e_mis) m_mc++;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic jump_to(input logic [31:0] target);
        dec_is_jump   = 1'b1;
        dec_pc_target = target;
        cycle();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        #12;
        check("reset pc_f", pc_f, 32'h0);
        check("reset branch_cnt", branch_cnt, 32'h0);
        check("reset mispred_cnt", mispred_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Sequential stream
        for (int i = 0; i < 4; i++) begin
            check("seq pc_f", pc_f, 32'(4 * i));
            cycle();
        end
        check("seq end pc_f", pc_f, 32'h10);

        // Jump at 0x10
        dec_is_jump   = 1'b1;
        dec_pc_target = 32'h400;
        #1;
        check("jump pred", {31'd0, pred_taken_f}, 32'd1);
        cycle();
        check("jump pc_f", pc_f, 32'h400);

        // Train index of 0x20 twice taken: 01 -> 10 -> 11
        resolve(32'h20, 1'b1, 1'b1, 32'h100);
        cycle();
        resolve(32'h20, 1'b1, 1'b1, 32'h100);
        cycle();
        jump_to(32'h20);
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h100;
        #1;
        check("trained pred", {31'd0, pred_taken_f}, 32'd1);
        cycle();
        check("trained pc_f", pc_f, 32'h100);
        // Third taken saturates at 11; one not-taken then leaves 10 (still taken)
        resolve(32'h20, 1'b1, 1'b1, 32'h100);
        cycle();
        resolve(32'h20, 1'b0, 1'b0, 32'h100);
        cycle();
        jump_to(32'h20);
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h200;
        #1;
        check("saturated pred", {31'd0, pred_taken_f}, 32'd1);
        cycle();

        // Stall only: PC holds
        stall_f = 1'b1;
        cycle();
        check("stall pc_f", pc_f, 32'h200);

        // Mispredict overrides stall
        stall_f = 1'b1;
        resolve(32'h44, 1'b1, 1'b0, 32'h80);
        #1;
        check("mispredict flag", {31'd0, mispredict}, 32'd1);
        cycle();
        check("redirect pc_f", pc_f, 32'h80);
        check("mispred_cnt", mispred_cnt, 32'd1);
        // Not-taken mispredict redirects to fall-through
        resolve(32'h90, 1'b0, 1'b1, 32'h300);
        cycle();
        check("fallthrough pc_f", pc_f, 32'h94);

        // Same-index read/write at 0x60 (counter still 01)
        jump_to(32'h60);
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h500;
        stall_f       = 1'b1;
        resolve(32'h60, 1'b1, 1'b1, 32'h500);
        #1;
        check("same-cycle pred", {31'd0, pred_taken_f}, 32'd0);
        cycle();
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h500;
        #1;
        check("next-cycle pred", {31'd0, pred_taken_f}, 32'd1);
        cycle();
        // Aliased PC 0x160 shares the counter of 0x60
        jump_to(32'h160);
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h600;
        #1;
        check("alias pred", {31'd0, pred_taken_f}, 32'd1);
        cycle();
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset mid-run, between edges
        check("pre-reset branch_cnt", branch_cnt, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async reset pc_f", pc_f, 32'h0);
        check("async reset branch_cnt", branch_cnt, 32'h0);
        check("async reset mispred_cnt", mispred_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        cycle();
        jump_to(32'h20);
        dec_is_branch = 1'b1;
        dec_pc_target = 32'h100;
        #1;
        check("post-reset pred", {31'd0, pred_taken_f}, 32'd0);
        cycle();
        check("post-reset pc_f", pc_f, 32'h24);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
